// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM state and default sizing for the chunked adder
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CHUNK-bit ripple adder built from full_adder cells
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             c_in,
  output logic [CHUNK-1:0] s_c,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a (a_c[i]),
      .b (b_c[i]),
      .ci(c[i]),
      .s (s_c[i]),
      .co(c[i+1])
    );
  end

  // Carry into the top bit is what signed overflow detection needs on the last chunk.
  assign c_out    = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle adder/subtractor processing CHUNK bits per cycle
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_adder: CHUNK must be >= 1 and divide WIDTH");
  end

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_r, b_r, sum_r;
  logic              carry_r, cout_r, ovf_r;
  logic [CW-1:0]     cnt;
  logic              accept, last;

  logic [CHUNK-1:0]  a_cur, b_cur, s_c;
  logic              c_out, c_msb_in;
  logic [WIDTH-1:0]  sum_ins;
  int                sh;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(N - 1));

  // Slice the current chunk out of the latched operands and splice the result back in.
  always_comb begin
    sh      = int'(cnt) * CHUNK;
    a_cur   = CHUNK'(a_r >> sh);
    b_cur   = CHUNK'(b_r >> sh);
    sum_ins = (sum_r & ~(WIDTH'({CHUNK{1'b1}}) << sh)) | (WIDTH'(s_c) << sh);
  end

  adder_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a_c     (a_cur),
    .b_c     (b_cur),
    .c_in    (carry_r),
    .s_c     (s_c),
    .c_out   (c_out),
    .c_msb_in(c_msb_in)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        // Subtraction is A + ~B + 1, so the carry-in is forced and cin is ignored.
        a_r     <= a;
        b_r     <= sub ? ~b : b;
        carry_r <= sub ? 1'b1 : cin;
        cnt     <= '0;
      end else if (state == RUN) begin
        sum_r   <= sum_ins;
        carry_r <= c_out;
        cnt     <= last ? '0 : cnt + 1'b1;
        if (last) begin
          cout_r <= c_out;
          ovf_r  <= c_msb_in ^ c_out;
        end
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_chunked_adder.sv
// tb/tb_chunked_adder.sv - scoreboard bench driving CHUNK=4, 16 and 1 instances in lockstep
module tb_chunked_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic [2:0]  rdy, vld, cout_o, ovf_o;
  logic [15:0] sum_o [3];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rd_cnt [3] = '{0, 0, 0};
  logic mon_en = 1'b0;
  exp_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s chunk=%0d got=0x%0h expected=0x%0h", nm, ch, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    localparam int NC = 16 / CH;

    chunked_adder #(.WIDTH(16), .CHUNK(CH)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (rdy[g]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(vld[g]),
      .out_ready(out_ready),
      .sum      (sum_o[g]),
      .cout     (cout_o[g]),
      .ovf      (ovf_o[g])
    );

    initial begin : mon
      logic        seen;
      logic        hs;
      logic [17:0] held;
      exp_t        e;
      seen = 1'b0;
      hs   = 1'b0;
      held = '0;
      forever begin
        @(negedge clk);
        if (!mon_en || rst) begin
          seen = 1'b0;
          hs   = 1'b0;
        end else if (hs) begin
          check("release_idle", CH, {30'd0, vld[g], rdy[g]}, 32'h1);
          hs   = 1'b0;
          seen = 1'b0;
        end else if (vld[g]) begin
          if (!seen) begin
            if (rd_cnt[g] >= exp_q.size()) begin
              tests++;
              fails++;
              $display("FAIL unexpected_result chunk=%0d got=0x%0h expected=none", CH, sum_o[g]);
            end else begin
              e = exp_q[rd_cnt[g]];
              rd_cnt[g]++;
              check("sum", CH, 32'(sum_o[g]), 32'(e.s));
              check("cout", CH, 32'(cout_o[g]), 32'(e.c));
              check("ovf", CH, 32'(ovf_o[g]), 32'(e.o));
              check("latency", CH, 32'(cyc - e.acc), 32'(NC));
            end
            seen = 1'b1;
            held = {sum_o[g], cout_o[g], ovf_o[g]};
          end else begin
            check("hold", CH, {13'd0, rdy[g], sum_o[g], cout_o[g], ovf_o[g]}, {14'd0, held});
          end
          if (out_ready) hs = 1'b1;
        end else if (seen) begin
          tests++;
          fails++;
          $display("FAIL result_dropped chunk=%0d got=out_valid 0 expected=out_valid 1", CH);
          seen = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (rdy !== 3'b111 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    tests++;
    if (w >= 200) begin
      fails++;
      $display("FAIL wait_ready got=%b expected=111", rdy);
    end
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic is,
                       input logic [15:0] es, input logic ec, input logic eo, input logic push);
    exp_t e;
    wait_ready();
    a = ia;
    b = ib;
    cin = ic;
    sub = is;
    in_valid = 1'b1;
    if (push) begin
      e.s = es;
      e.c = ec;
      e.o = eo;
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble operands right after accept; the result must not follow them.
    in_valid = 1'b0;
    a = ~ia ^ 16'h5a5a;
    b = ib + 16'h1357;
    cin = ~ic;
    sub = ~is;
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("reset_ready", g, 32'(rdy[g]), 32'h1);
      check("reset_valid", g, 32'(vld[g]), 32'h0);
      check("reset_sum", g, 32'(sum_o[g]), 32'h0);
      check("reset_cout_ovf", g, {30'd0, cout_o[g], ovf_o[g]}, 32'h0);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    issue(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    issue(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1);
    issue(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: hold the result while in_valid stays high with moving operands.
    wait_ready();
    out_ready = 1'b0;
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 26; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_ready();
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a run, with the CHUNK=4 instance about to add chunk 2.
    mon_en = 1'b0;
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("midrun_rst_ready", g, 32'(rdy[g]), 32'h1);
      check("midrun_rst_valid", g, 32'(vld[g]), 32'h0);
      check("midrun_rst_sum", g, 32'(sum_o[g]), 32'h0);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);

    w = 0;
    while ((rd_cnt[0] != exp_q.size() || rd_cnt[1] != exp_q.size() ||
            rd_cnt[2] != exp_q.size() || rdy !== 3'b111) && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (2) @(posedge clk);
    for (int g = 0; g < 3; g++) check("results_seen", g, 32'(rd_cnt[g]), 32'(exp_q.size()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
